// File: rtl/sb_arb_pkg.sv
// Shared definitions for the switchboard round-robin arbiter.
// Holds the state encoding and a clog2 helper used for pointer widths.
package sb_arb_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    typedef enum logic {
        IDLE   = ST_IDLE,
        LOCKED = ST_LOCKED
    } sb_arb_state_t;

    // Index width for n entries; never below 1 bit.
    function automatic int sb_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sb_rr_arbiter_if.sv
// Switchboard bundle: NIN flat input channels and one output channel.
// slave = arbiter side, master = traffic source / sink side.
interface sb_rr_arbiter_if #(
    parameter int DW  = 256,
    parameter int NIN = 4
);

    logic [NIN*DW-1:0] in_data;
    logic [NIN*32-1:0] in_dest;
    logic [NIN-1:0]    in_last;
    logic [NIN-1:0]    in_valid;
    logic [NIN-1:0]    in_ready;
    logic [DW-1:0]     out_data;
    logic [31:0]       out_dest;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_dest, in_last, in_valid, out_ready,
        output in_ready, out_data, out_dest, out_last, out_valid
    );

    modport master (
        output in_data, in_dest, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_dest, out_last, out_valid
    );

endinterface

// File: rtl/sb_rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, mod NIN.
// Ports: req[NIN], ptr in; pick index and any_valid out.  Combinational.
module sb_rr_pick
    import sb_arb_pkg::*;
#(
    parameter int NIN = 4,
    parameter int PW  = sb_clog2(NIN)
) (
    input  logic [NIN-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [PW-1:0]  pick,
    output logic           any_valid
);

    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NIN; k++) begin
            if (!any_valid && req[(int'(ptr) + k) % NIN]) begin
                pick      = PW'((int'(ptr) + k) % NIN);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_rr_arbiter.sv
// Packet-aware round-robin merge of NIN channels into one registered output.
// Ports: clk, rst (sync, high), bus (sb_rr_arbiter_if.slave).
module sb_rr_arbiter
    import sb_arb_pkg::*;
#(
    parameter int DW  = 256,
    parameter int NIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    sb_rr_arbiter_if.slave    bus
);

    localparam int PW = sb_clog2(NIN);

    sb_arb_state_t   state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   owner, owner_n;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   gidx;
    logic            any_valid;
    logic            slot_free;
    logic            grant_en;
    logic            xfer;
    logic            sel_last;
    logic [NIN-1:0]  ready;

    logic [DW-1:0]   ob_data;
    logic [31:0]     ob_dest;
    logic            ob_last;
    logic            ob_valid;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
        return (int'(x) == NIN - 1) ? '0 : x + 1'b1;
    endfunction

    sb_rr_pick #(
        .NIN (NIN),
        .PW  (PW)
    ) u_pick (
        .req       (bus.in_valid),
        .ptr       (ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign slot_free = !ob_valid || bus.out_ready;

    // Locked grant stays on the owner even when it has no beat pending.
    assign gidx     = (state == LOCKED) ? owner : pick;
    assign grant_en = (state == LOCKED) || any_valid;

    always_comb begin
        ready = '0;
        if (!rst && grant_en && slot_free) begin
            ready[gidx] = 1'b1;
        end
    end

    assign xfer     = bus.in_valid[gidx] && ready[gidx];
    assign sel_last = bus.in_last[gidx];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_n = nxt(pick);
                    end else begin
                        state_n = LOCKED;
                        owner_n = pick;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_n = IDLE;
                    ptr_n   = nxt(owner);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ob_valid <= 1'b0;
            ob_data  <= '0;
            ob_dest  <= '0;
            ob_last  <= 1'b0;
        end else if (xfer) begin
            ob_valid <= 1'b1;
            ob_data  <= bus.in_data[int'(gidx) * DW +: DW];
            ob_dest  <= bus.in_dest[int'(gidx) * 32 +: 32];
            ob_last  <= sel_last;
        end else if (bus.out_ready) begin
            ob_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = ob_data;
    assign bus.out_dest  = ob_dest;
    assign bus.out_last  = ob_last;
    assign bus.out_valid = ob_valid;

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// Directed bench for sb_rr_arbiter (NIN=4, DW=32).
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_sb_rr_arbiter;

    localparam int DW  = 32;
    localparam int NIN = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sb_rr_arbiter_if #(.DW(DW), .NIN(NIN)) bus ();

    sb_rr_arbiter #(
        .DW  (DW),
        .NIN (NIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drv(input int ch, input logic v, input logic l,
                       input logic [31:0] d);
        bus.in_valid[ch]           = v;
        bus.in_last[ch]            = l;
        bus.in_data[ch*DW +: DW]   = d;
        bus.in_dest[ch*32 +: 32]   = d ^ 32'hA5A5_0000;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NIN; i++) drv(i, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NIN; i++) drv(i, 1'b1, 1'b1, 32'hC0 + i);
        tick();

        // Reset held with every channel valid.
        for (int c = 0; c < 3; c++) begin
            neg();
            chk("rst_rdy", 64'(bus.in_ready), 64'h0);
            chk("rst_ov", 64'(bus.out_valid), 64'h0);
            chk("rst_od", 64'(bus.out_data), 64'h0);
            tick();
        end
        rst = 1'b0;

        // Fairness: single-beat packets everywhere.
        for (int k = 0; k < 8; k++) begin
            neg();
            chk("fair_rdy", 64'(bus.in_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("fair_ov", 64'(bus.out_valid), 64'h1);
                chk("fair_od", 64'(bus.out_data), 64'hC0 + 64'((k - 1) % 4));
            end
            tick();
        end
        neg();
        chk("fair_end", 64'(bus.out_data), 64'hC3);
        chk("fair_dest", 64'(bus.out_dest), 64'hA5A5_00C3);

        // Packet lock on ch1 with a two-cycle valid gap.
        do_reset();
        drv(0, 1'b1, 1'b1, 32'hA0);
        neg();
        chk("lk_a_rdy", 64'(bus.in_ready), 64'b0001);
        tick();
        drv(0, 1'b1, 1'b1, 32'hD0);
        drv(1, 1'b1, 1'b0, 32'hB1);
        drv(2, 1'b1, 1'b1, 32'hD2);
        neg();
        chk("lk_b_rdy", 64'(bus.in_ready), 64'b0010);
        chk("lk_b_od", 64'(bus.out_data), 64'hA0);
        tick();
        drv(1, 1'b0, 1'b0, 32'h0);
        neg();
        chk("lk_c_rdy", 64'(bus.in_ready), 64'b0010);
        chk("lk_c_od", 64'(bus.out_data), 64'hB1);
        chk("lk_c_ol", 64'(bus.out_last), 64'h0);
        tick();
        neg();
        chk("lk_d_rdy", 64'(bus.in_ready), 64'b0010);
        chk("lk_d_ov", 64'(bus.out_valid), 64'h0);
        tick();
        drv(1, 1'b1, 1'b0, 32'hB2);
        neg();
        chk("lk_e_rdy", 64'(bus.in_ready), 64'b0010);
        tick();
        drv(1, 1'b1, 1'b1, 32'hB3);
        neg();
        chk("lk_f_od", 64'(bus.out_data), 64'hB2);
        chk("lk_f_rdy", 64'(bus.in_ready), 64'b0010);
        tick();
        drv(1, 1'b0, 1'b0, 32'h0);
        neg();
        chk("lk_g_od", 64'(bus.out_data), 64'hB3);
        chk("lk_g_ol", 64'(bus.out_last), 64'h1);
        chk("lk_g_rdy", 64'(bus.in_ready), 64'b0100);
        tick();
        neg();
        chk("lk_h_od", 64'(bus.out_data), 64'hD2);
        idle_all();

        // Backpressure on a ch3 stream.
        do_reset();
        drv(3, 1'b1, 1'b0, 32'h11);
        neg();
        chk("bp0_rdy", 64'(bus.in_ready), 64'b1000);
        tick();
        drv(3, 1'b1, 1'b0, 32'h22);
        neg();
        chk("bp1_od", 64'(bus.out_data), 64'h11);
        chk("bp1_rdy", 64'(bus.in_ready), 64'b1000);
        tick();
        drv(3, 1'b1, 1'b1, 32'h33);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            neg();
            chk("bp_st_od", 64'(bus.out_data), 64'h22);
            chk("bp_st_ov", 64'(bus.out_valid), 64'h1);
            chk("bp_st_rdy", 64'(bus.in_ready), 64'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        neg();
        chk("bp4_od", 64'(bus.out_data), 64'h22);
        chk("bp4_rdy", 64'(bus.in_ready), 64'b1000);
        tick();
        drv(3, 1'b0, 1'b0, 32'h0);
        neg();
        chk("bp5_od", 64'(bus.out_data), 64'h33);
        chk("bp5_ol", 64'(bus.out_last), 64'h1);
        tick();
        neg();
        chk("bp6_ov", 64'(bus.out_valid), 64'h0);

        // Pointer wrap 3 -> 0 -> 1.
        do_reset();
        drv(2, 1'b1, 1'b1, 32'h52);
        neg();
        chk("wr0_rdy", 64'(bus.in_ready), 64'b0100);
        tick();
        drv(2, 1'b0, 1'b0, 32'h0);
        drv(3, 1'b1, 1'b1, 32'h53);
        drv(0, 1'b1, 1'b1, 32'h50);
        neg();
        chk("wr1_rdy", 64'(bus.in_ready), 64'b1000);
        tick();
        neg();
        chk("wr2_rdy", 64'(bus.in_ready), 64'b0001);
        chk("wr2_od", 64'(bus.out_data), 64'h53);
        tick();
        neg();
        chk("wr3_rdy", 64'(bus.in_ready), 64'b1000);
        chk("wr3_od", 64'(bus.out_data), 64'h50);
        idle_all();

        // Reset in the middle of a 4-beat ch2 packet.
        do_reset();
        drv(2, 1'b1, 1'b0, 32'h61);
        neg();
        chk("rm0_rdy", 64'(bus.in_ready), 64'b0100);
        tick();
        drv(2, 1'b1, 1'b0, 32'h62);
        neg();
        chk("rm1_od", 64'(bus.out_data), 64'h61);
        tick();
        rst = 1'b1;
        drv(2, 1'b1, 1'b0, 32'h63);
        drv(0, 1'b1, 1'b1, 32'h70);
        neg();
        chk("rm2_rdy", 64'(bus.in_ready), 64'h0);
        chk("rm2_od", 64'(bus.out_data), 64'h62);
        tick();
        rst = 1'b0;
        neg();
        chk("rm3_ov", 64'(bus.out_valid), 64'h0);
        chk("rm3_rdy", 64'(bus.in_ready), 64'b0001);
        tick();
        neg();
        chk("rm4_od", 64'(bus.out_data), 64'h70);
        idle_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
